// File: rtl/ztex_work_rx.sv
// Host byte receiver: synchronizes the EZ-USB strobe, assembles a double-buffered work frame.
// Optional WORK_CHECKSUM_EN: trailing XOR byte per frame, mismatching frames dropped, cksum_err pulse.
module ztex_work_rx #(
    parameter int WORK_BYTES = 80,
    parameter int CNT_W      = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    select,
    input  logic                    rd_clk,
    input  logic [7:0]              read,
    output logic [8*WORK_BYTES-1:0] work_data,
    output logic                    work_valid,
    input  logic                    work_ready,
    output logic [CNT_W-1:0]        byte_count,
    output logic                    overrun
`ifdef WORK_CHECKSUM_EN
    ,
    output logic                    cksum_err
`endif
);

`ifdef WORK_CHECKSUM_EN
    localparam int LAST = WORK_BYTES;
`else
    localparam int LAST = WORK_BYTES - 1;
`endif

    typedef enum logic {FILL, HOLD} state_t;
    state_t state, state_nx;

    logic                    rd_s1, rd_s2, rd_d;
    logic                    sel_s1, sel_s2, sel_d;
    logic [1:0]              warm;
    logic                    armed;
    logic [8*WORK_BYTES-1:0] fill;
    logic                    load_pend;
    logic                    ev, sel_rise, hs, last_byte, cksum_ok;
    logic                    accept, done, drop, hold_load;

`ifdef WORK_CHECKSUM_EN
    logic [7:0] xsum;
    logic       bad;
    assign cksum_ok = (read == xsum);
`else
    assign cksum_ok = 1'b1;
`endif

    // armed only after the synchronized strobe has been seen low post-reset,
    // so a strobe already high at reset release never counts as an edge
    assign ev        = rd_s2 & ~rd_d & armed;
    assign sel_rise  = sel_s2 & ~sel_d;
    assign hs        = work_valid & work_ready;
    assign last_byte = (byte_count == CNT_W'(LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        done      = 1'b0;
        drop      = 1'b0;
        hold_load = 1'b0;
        if (sel_rise) begin
            state_nx = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (ev && sel_s2) begin
                        accept = 1'b1;
                        if (last_byte && cksum_ok) begin
                            done = 1'b1;
                            if (work_valid && !work_ready)
                                state_nx = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hs) begin
                        hold_load = 1'b1;
                        state_nx  = FILL;
                    end
                    if (ev && sel_s2)
                        drop = 1'b1;
                end
                default: state_nx = FILL;
            endcase
        end
    end

`ifdef WORK_CHECKSUM_EN
    assign bad = accept & last_byte & ~cksum_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_s1      <= 1'b0;
            rd_s2      <= 1'b0;
            rd_d       <= 1'b0;
            sel_s1     <= 1'b0;
            sel_s2     <= 1'b0;
            sel_d      <= 1'b0;
            warm       <= 2'b00;
            armed      <= 1'b0;
            fill       <= '0;
            work_data  <= '0;
            work_valid <= 1'b0;
            load_pend  <= 1'b0;
            byte_count <= '0;
            overrun    <= 1'b0;
        end else begin
            rd_s1  <= rd_clk;
            rd_s2  <= rd_s1;
            rd_d   <= rd_s2;
            sel_s1 <= select;
            sel_s2 <= sel_s1;
            sel_d  <= sel_s2;
            warm   <= {warm[0], 1'b1};
            armed  <= armed | (warm[1] & ~rd_s2);

            // completed frame is copied one edge after its last byte lands in fill
            load_pend <= done & (~work_valid | work_ready);
            if (load_pend || hold_load) begin
                work_data  <= fill;
                work_valid <= 1'b1;
            end else if (hs) begin
                work_valid <= 1'b0;
            end

            if (sel_rise) begin
                byte_count <= '0;
                overrun    <= 1'b0;
                fill       <= '0;
            end else begin
                if (accept) begin
                    byte_count <= last_byte ? '0 : byte_count + 1'b1;
                    for (int k = 0; k < WORK_BYTES; k++)
                        if (byte_count == CNT_W'(k))
                            fill[8*k +: 8] <= read;
                end
                if (drop)
                    overrun <= 1'b1;
            end
        end
    end

`ifdef WORK_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xsum      <= 8'h00;
            cksum_err <= 1'b0;
        end else begin
            cksum_err <= bad;
            if (accept)
                xsum <= (byte_count == '0) ? read : (xsum ^ read);
        end
    end
`endif

endmodule

// File: doc/ztex_work_rx.md
Name: ztex_work_rx

Overview:
- Host-side byte receiver that sits directly upstream of the miner core inside the ztex_ufm1_15y1 top.
- Captures bytes strobed by the EZ-USB on read[7:0]/rd_clk and assembles them into a complete work frame: a block header, little-endian.
- Hands the frame to the hashing core over a valid/ready handshake.
- Double-buffered: the next frame can stream in while the core still holds the previous one.

Parameters:
- WORK_BYTES, 80: bytes per work frame. Legal range 2..128.
- CNT_W, 7: width of the byte counter. Must satisfy 2^CNT_W > WORK_BYTES.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- select  in  1  chip select. Bytes are ignored while low. A rising edge restarts the frame.
- rd_clk  in  1  asynchronous byte strobe from the host. A byte is presented on each rising edge.
- read  in  8  host data byte. Held stable for at least 4 clk cycles after the rd_clk rise.
- work_data  out  8*WORK_BYTES  frame in the holding register. Byte k is at [8k+7:8k].
- work_valid  out  1  holding register contains an unconsumed frame.
- work_ready  in  1  core accepts the frame. Transfer occurs on any cycle where work_valid and work_ready are both high.
- byte_count  out  CNT_W  bytes received into the current (fill) frame.
- overrun  out  1  sticky flag: at least one byte was dropped.

Behaviour:
- Reset values:
  - work_data = 0, work_valid = 0, byte_count = 0, overrun = 0, fill buffer = 0, state = FILL.
  - Synchronizer flops reset to 0. A strobe already high at reset release does not produce an edge.
- Strobe path:
  - rd_clk and select each pass through a 2-flop synchronizer, followed by an edge register.
  - A strobe event is a synchronized 0->1 transition on rd_clk. This gives exactly one event per host strobe.
  - read is sampled on the cycle the event is detected. Strobe-to-capture latency is 3 clk.
- Byte acceptance in FILL with select_sync high:
  - The byte is written to fill[8*byte_count +: 8].
  - byte_count increments by 1.
- Frame completion:
  - Occurs when the accepted byte is number WORK_BYTES-1 (0-based).
  - byte_count returns to 0 (no wrap past WORK_BYTES).
  - If the holding register is free, or is being consumed this same cycle, the fill buffer is copied to work_data on the next edge. work_valid is high 1 cycle after the last byte is captured. State stays FILL.
  - Otherwise the state goes to HOLD.
- HOLD state:
  - Entered when a frame is complete but the holding register is occupied.
  - On the cycle work_valid and work_ready are both high: work_data <= fill next cycle, work_valid stays 1, state -> FILL.
  - Any strobe event while in HOLD drops the byte and sets overrun.
- work_valid deasserts the cycle after a handshake, unless a new frame is loaded on that same edge.
- work_data is stable while work_valid is high and not yet accepted.
- Strobes while select_sync is low: ignored. byte_count and overrun are unchanged.
- select_sync rising edge:
  - Sets byte_count to 0 and clears overrun.
  - Discards a partial fill. In HOLD, also discards the full fill buffer and returns to FILL.
  - Does not touch work_data or work_valid.
  - If it coincides with a strobe event, the restart wins and that byte is dropped (overrun is not set).
- Reset mid-frame: everything returns to reset values within 1 cycle. Partial frames and the pending frame are lost.

Optional Feature:
- Macro WORK_CHECKSUM_EN.
- When defined:
  - The host sends WORK_BYTES+1 bytes. The extra last byte is the XOR of all preceding bytes of the frame.
  - A running XOR register is cleared at frame start.
  - On mismatch, the frame is discarded (never reaches work_data or HOLD) and byte_count returns to 0.
  - An extra output port cksum_err (1 bit, reset 0) pulses for 1 cycle on mismatch.
  - CNT_W must cover WORK_BYTES+1.
- When undefined: no checksum byte, no XOR register, no cksum_err port.

Test Plan:
- T1: reset, select high, 80 strobes with bytes 0x00..0x4F, work_ready=0 -> work_valid=1 3+1 clk after the final strobe; work_data[7:0]=0x00, work_data[639:632]=0x4F; byte_count=0.
- T2: T1 state held, send a 2nd frame of all 0xA5, then 1 extra strobe -> HOLD entered, extra byte dropped, overrun=1. Pulse work_ready for 1 cycle -> next cycle work_data = all 0xA5, work_valid=1.
- T3: 10 bytes sent, then select low->high, then a full frame 0x10..0x5F -> work_data[7:0]=0x10, no residue of the partial frame, overrun=0.
- T4: strobes with select low -> byte_count stays 0, work_valid stays 0. rd_clk held high across reset release -> no byte captured.
- T5: assert reset after 40 bytes -> byte_count=0 next cycle. A following full frame is delivered intact.
- T6 (WORK_CHECKSUM_EN, WORK_BYTES=4): bytes 01 02 04 08 0F -> frame accepted. Bytes 01 02 04 08 00 -> cksum_err pulses 1 cycle, work_valid stays 0.
